// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester shared logic unit:
// op encoding constants and the arbiter/FSM state enumeration.
package alu_share_arb_pkg;

  // Two-bit op codes presented on req_op
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  // IDLE arbitrates and captures, EXEC evaluates, RESP holds the result
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_share_arb_logic_unit.sv
// Combinational bitwise logic unit shared by both requesters.
// Pure function of op/a/b; no carry chain, result is exactly W bits.
module logic_unit
  import alu_share_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result
);

  // Select the bitwise operation named by op
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one logic unit. A round-robin arbiter grants one
// request in IDLE, the operands are captured at the grant edge, the result
// is registered in EXEC and held in RESP until the consumer takes it.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0][1:0]   req_op,
  input  logic [1:0][W-1:0] req_a,
  input  logic [1:0][W-1:0] req_b,
  output logic [1:0]        req_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [W-1:0]      rsp_data,
  input  logic              rsp_ready
);

  state_t       state;
  logic         ptr;
  logic         win_id;
  logic [1:0]   grant;
  logic [1:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         id_q;
  logic [W-1:0] lu_result;

  // Round-robin pick: pointer breaks ties, a lone requester always wins.
  // Gated with rst_n so no accept is signalled while reset is held.
  always_comb begin
    win_id = 1'b0;
    if (req_valid == 2'b11) begin
      win_id = ptr;
    end else if (req_valid[1]) begin
      win_id = 1'b1;
    end
    grant = 2'b00;
    if (rst_n && (state == ST_IDLE) && (|req_valid)) begin
      grant[win_id] = 1'b1;
    end
  end

  assign req_ready = grant;

  logic_unit #(
    .W(W)
  ) u_logic_unit (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .result(lu_result)
  );

  // Control FSM with capture and result registers; reset discards any
  // in-flight operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            op_q  <= req_op[win_id];
            a_q   <= req_a[win_id];
            b_q   <= req_b[win_id];
            id_q  <= win_id;
            ptr   <= ~win_id;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= lu_result;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          // Returning to IDLE first keeps accept and next grant in separate cycles
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: directed scenarios plus randomized traffic,
// each cycle compared against a transaction-level reference model.
module tb_alu_share_arb;

  localparam int W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0][1:0]   req_op;
  logic [1:0][W-1:0] req_a;
  logic [1:0][W-1:0] req_b;
  logic [1:0]        req_ready;
  logic              rsp_valid;
  logic              rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one operation in flight at most
  bit   m_busy;
  int   m_age;
  int   m_ptr;
  int   m_id;
  int   m_data;

  // Observations
  int   grants[$];
  bit   got_resp;
  int   last_id;
  int   last_data;
  int   hold_id;
  int   hold_data;

  always #5 clk = ~clk;

  alu_share_arb #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_ready(rsp_ready)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit arithmetic definition of the four ops
  function automatic int ref_op(input int op, input int a, input int b);
    int r;
    r = 0;
    for (int i = 0; i < W; i++) begin
      int x, y, z;
      x = (a >> i) & 1;
      y = (b >> i) & 1;
      case (op)
        0:       z = x * y;
        1:       z = x + y - x * y;
        2:       z = (x + y) % 2;
        default: z = 1 - (x + y) % 2;
      endcase
      r += z << i;
    end
    return r;
  endfunction

  function automatic int pick(input logic [1:0] v, input int p);
    if (v == 2'b11) return p;
    if (v[1]) return 1;
    return 0;
  endfunction

  task automatic mdl_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_ptr  = 0;
    m_id   = 0;
    m_data = 0;
  endtask

  // One clock: check outputs at the falling edge, advance model at the rising edge
  task automatic step();
    int exp_ready;
    bit exp_valid;
    @(negedge clk);
    exp_ready = 0;
    if (rst_n && !m_busy && (req_valid != 2'b00)) exp_ready = 1 << pick(req_valid, m_ptr);
    exp_valid = m_busy && (m_age >= 2);
    chk("req_ready", int'(req_ready), exp_ready);
    chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
    chk("rsp_valid", int'(rsp_valid), int'(exp_valid));
    if (exp_valid) begin
      chk("rsp_id", int'(rsp_id), m_id);
      chk("rsp_data", int'(rsp_data), m_data);
    end
    if (req_ready != 2'b00) grants.push_back(int'(req_ready[1]));
    if (rsp_valid && rsp_ready) begin
      got_resp  = 1'b1;
      last_id   = int'(rsp_id);
      last_data = int'(rsp_data);
    end
    @(posedge clk);
    if (!rst_n) begin
      mdl_reset();
    end else if (m_busy) begin
      if (m_age >= 2) begin
        if (rsp_ready) m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end else if (req_valid != 2'b00) begin
      int w;
      w      = pick(req_valid, m_ptr);
      m_data = ref_op(int'(req_op[w]), int'(req_a[w]), int'(req_b[w]));
      m_id   = w;
      m_ptr  = 1 - w;
      m_busy = 1'b1;
      m_age  = 1;
    end
    #1;
  endtask

  task automatic run_until_accept(input int budget);
    got_resp = 1'b0;
    for (int i = 0; i < budget && !got_resp; i++) step();
    chk("resp_timeout", int'(got_resp), 1);
  endtask

  task automatic set_req(input int r, input int op, input int a, input int b);
    req_op[r] = 2'(op);
    req_a[r]  = 4'(a);
    req_b[r]  = 4'(b);
  endtask

  initial begin
    int exp_tab[4];
    exp_tab = '{8, 14, 6, 9};

    // Reset state with requests pending
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    mdl_reset();
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    step();
    step();
    req_valid = 2'b00;
    rst_n = 1'b1;
    step();

    // Single AND on requester 0
    grants.delete();
    set_req(0, 0, 'hC, 'hA);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    run_until_accept(8);
    chk("single_grant", grants.size(), 1);
    chk("single_id", last_id, 0);
    chk("single_data", last_data, 8);

    // All ops on requester 1
    for (int op = 0; op < 4; op++) begin
      set_req(1, op, 'hC, 'hA);
      req_valid = 2'b10;
      step();
      req_valid = 2'b00;
      run_until_accept(8);
      chk("op_id", last_id, 1);
      chk("op_data", last_data, exp_tab[op]);
    end

    // Backpressure for five cycles while both request
    set_req(0, 2, 3, 5);
    set_req(1, 1, 1, 2);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    step();
    req_valid = 2'b11;
    step();
    step();
    hold_id   = int'(rsp_id);
    hold_data = int'(rsp_data);
    chk("bp_data", hold_data, 6);
    grants.delete();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", int'(rsp_valid), 1);
      chk("bp_hold_id", int'(rsp_id), hold_id);
      chk("bp_hold_data", int'(rsp_data), hold_data);
    end
    chk("bp_no_grant", grants.size(), 0);
    rsp_ready = 1'b1;
    run_until_accept(4);
    step();
    chk("bp_next_grant", grants.size(), 1);
    if (grants.size() > 0) chk("bp_next_id", grants[0], 1);
    req_valid = 2'b00;
    run_until_accept(8);
    step();

    // Operand change after grant is ignored
    set_req(0, 1, 'hF, 0);
    req_valid = 2'b01;
    step();
    req_a[0]  = 4'h0;
    req_valid = 2'b00;
    run_until_accept(8);
    chk("late_change_data", last_data, 'hF);

    // Reset in EXEC discards the op; then both held from reset alternate
    set_req(1, 3, 5, 5);
    req_valid = 2'b10;
    step();
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk("midrst_req_ready", int'(req_ready), 0);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_rsp_id", int'(rsp_id), 0);
    chk("midrst_rsp_data", int'(rsp_data), 0);
    step();
    step();
    rst_n = 1'b1;
    grants.delete();
    for (int i = 0; i < 15; i++) begin
      set_req(0, int'($urandom_range(3, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
      set_req(1, int'($urandom_range(3, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
      step();
    end
    chk("alt_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("alt_order", grants[i], i % 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(3, 0) != 0);
      set_req(0, int'($urandom_range(3, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
      set_req(1, int'($urandom_range(3, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter: W, 4, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_op  input  2x2  per-requester op: 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-006 req_a  input  2xW  per-requester operand A.
REQ-007 req_b  input  2xW  per-requester operand B.
REQ-008 req_ready  output  2  per-requester accept; at most one bit high in any cycle.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  1  requester index that owns the result.
REQ-011 rsp_data  output  W  result of the granted op.
REQ-012 rsp_ready  input  1  consumer accepts the result.

Function
REQ-013 The block SHALL share one logic unit between two requesters using a 3-state FSM: IDLE, EXEC, RESP.
REQ-014 IDLE: if any req_valid is high, the block SHALL assert req_ready for the winner combinationally, capture op/A/B into registers at that edge, record the winner id, and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-015 req_ready SHALL be zero in EXEC and RESP.
REQ-016 Arbitration SHALL be round-robin: a 1-bit priority pointer names the preferred requester; if only one requests, it wins regardless of the pointer.
REQ-017 On every grant the pointer SHALL move to the non-granted requester.
REQ-018 EXEC: the captured op SHALL be applied to the captured operands, the W-bit result registered, and the FSM SHALL go to RESP; no arithmetic carry, result width equals W.
REQ-019 RESP: rsp_valid SHALL be high; rsp_data and rsp_id SHALL stay stable until rsp_ready is sampled high, after which the FSM returns to IDLE and rsp_valid drops the next cycle.
REQ-020 Minimum latency: grant edge to rsp_valid high = 2 cycles; back-to-back throughput = one op per 3 cycles with rsp_ready held high.
REQ-021 A new request SHALL NOT be granted in the same cycle a response is accepted (no IDLE skip).
REQ-022 Changes on req_* of a non-granted requester, or of any requester outside the grant cycle, SHALL NOT affect the in-flight operation.
REQ-023 Requests withdrawn before grant SHALL simply not be served; no error state exists.
REQ-024 With both requesters valid continuously, grants SHALL alternate 0,1,0,1... (or 1,0,... per pointer), so no requester waits more than one foreign op.

Reset
REQ-025 While rst_n is low: FSM = IDLE, pointer = 0 (requester 0 preferred), req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, captured registers = 0.
REQ-026 Reset asserted mid-operation (EXEC or RESP) SHALL discard the operation immediately; no response is produced for it after reset release.
REQ-027 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-028 A shared package SHALL hold the op encoding constants (AND/OR/XOR/XNOR) and the FSM state enumeration.
REQ-029 The combinational op evaluation SHALL be a sub-module named logic_unit (inputs op, A, B; output result, W wide), instantiated once.
REQ-030 Arbiter, FSM and capture registers SHALL live in alu_share_arb.

Verification
REQ-031 Single op: req 0 valid, op 00, A=4'hC, B=4'hA, rsp_ready=1 -> req_ready[0] high one cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_data=4'h8.
REQ-032 All ops on requester 1 with A=4'hC, B=4'hA -> rsp_data 8, E, 6, 9 for ops 00, 01, 10, 11, rsp_id=1.
REQ-033 Both valid from reset, held -> grants 0,1,0,1; never both req_ready bits high.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data constant; no new grant until rsp_ready=1.
REQ-035 Operand change after grant: req 0 changes A from 4'hF to 4'h0 the cycle after grant with op 01, B=0 -> rsp_data=4'hF.
REQ-036 Reset pulse in EXEC -> all outputs 0 immediately, next grant goes to requester 0 when both valid.
